// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for the EX stage.
// Computes RV32M MUL/MULH/MULHSU/MULHU on magnitudes, then fixes the sign.
module mul_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mul_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int N  = DATA_W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  acc;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic [1:0]      op_q;
  logic            sign_a;
  logic            sign_b;

  logic            sa_in;
  logic            sb_in;
  logic [N-1:0]    mag_a;
  logic [N-1:0]    mag_b;
  logic [N:0]      sum;
  logic [2*N-1:0]  acc_nxt;
  logic [2*N-1:0]  p_fin;
  logic [N-1:0]    res_nxt;

  // Operand signs/magnitudes and one shift-add step of the accumulator.
  always_comb begin
    sa_in   = ((mul_op == OP_MULH) || (mul_op == OP_MULHSU)) & op_a[N-1];
    sb_in   = (mul_op == OP_MULH) & op_b[N-1];
    mag_a   = sa_in ? (~op_a + 1'b1) : op_a;
    mag_b   = sb_in ? (~op_b + 1'b1) : op_b;
    sum     = {1'b0, acc[2*N-1:N]}
            + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
    acc_nxt = {sum, acc[N-1:1]};
    p_fin   = (sign_a ^ sign_b) ? (~acc_nxt + 1'b1) : acc_nxt;
    res_nxt = (op_q == OP_MUL) ? p_fin[N-1:0] : p_fin[2*N-1:N];
  end

  assign busy  = (state == BUSY);
  assign stall = (start & (state == IDLE) & ~flush) | busy;

  // Control FSM plus datapath registers; done trails the DONE state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state  <= BUSY;
            op_q   <= mul_op;
            sign_a <= sa_in;
            sign_b <= sb_in;
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              state  <= DONE;
              result <= res_nxt;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed testbench for mul_unit.
// Hand-computed vectors, per-scenario tasks with inline checks.
module tb_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mul_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  mul_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mul_op (mul_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    mul_op = op;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_on_start: got %b want 1", stall);
    end
    tick();
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h1234_5678;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b want 1", busy);
    end
  endtask

  task automatic run_op(input string name,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp);
    int sa;
    int da;
    sa = -1;
    da = -1;
    accept(op, a, b);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (!stall && sa < 0) sa = k;
      if (done) begin
        da = k;
        break;
      end
    end
    n_checks++;
    if (da != 33) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d want 33", name, da);
    end
    n_checks++;
    if (sa != 32) begin
      n_fail++;
      $display("FAIL %s stall_drop: got %0d want 32", name, sa);
    end
    n_checks++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", name, result, exp);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== exp) begin
      n_fail++;
      $display("FAIL %s hold: done %b result %h want 0 %h",
               name, done, result, exp);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    mul_op = 2'b00;
    op_a   = '0;
    op_b   = '0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0
        || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy %b done %b stall %b result %h",
               busy, done, stall, result);
    end
  endtask

  task automatic test_arith();
    run_op("mul_7x6",     2'b00, 32'd7,        32'd6,        32'h0000002A);
    run_op("mulhu_ff",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mul_ff",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("mulh_min",    2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulh_m1",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_op("mulhsu_ff",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mul_neg",     2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA);
    run_op("mulh_neg",    2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulhu_2p33",  2'b11, 32'h80000000, 32'd4,        32'h00000002);
    run_op("mulhsu_min2", 2'b10, 32'h80000000, 32'd2,        32'hFFFFFFFF);
    run_op("mul_zero",    2'b00, 32'd0,        32'hFFFFFFFF, 32'h00000000);
  endtask

  task automatic test_start_ignored();
    int pulses;
    int da;
    pulses = 0;
    da = -1;
    accept(2'b00, 32'd7, 32'd6);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd3;
      end
      tick();
      start = 1'b0;
      if (done) begin
        pulses++;
        if (da < 0) da = k;
      end
    end
    n_checks++;
    if (pulses != 1 || da != 33) begin
      n_fail++;
      $display("FAIL start_ignored_done: pulses %0d at %0d want 1 at 33",
               pulses, da);
    end
    n_checks++;
    if (result !== 32'h2A) begin
      n_fail++;
      $display("FAIL start_ignored_result: got %h want 0000002a", result);
    end
  endtask

  task automatic test_flush_busy();
    int pulses;
    pulses = 0;
    accept(2'b00, 32'd9, 32'd9);
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy_idle: busy %b stall %b want 0 0",
               busy, stall);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    n_checks++;
    if (pulses != 0 || result !== 32'h2A) begin
      n_fail++;
      $display("FAIL flush_busy_nodone: pulses %0d result %h want 0 2a",
               pulses, result);
    end
    run_op("mul_2x5", 2'b00, 32'd2, 32'd5, 32'h0000000A);
  endtask

  task automatic test_flush_done();
    int pulses;
    pulses = 0;
    accept(2'b00, 32'd11, 32'd11);
    for (int k = 1; k < 32; k++) tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (done) pulses++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) pulses++;
    end
    n_checks++;
    if (pulses != 1 || result !== 32'd121) begin
      n_fail++;
      $display("FAIL flush_done: pulses %0d result %h want 1 79",
               pulses, result);
    end
  endtask

  task automatic test_flush_start();
    mul_op = 2'b00;
    op_a   = 32'd5;
    op_b   = 32'd5;
    start  = 1'b1;
    flush  = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_stall: got %b want 0", stall);
    end
    tick();
    start = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_reject: busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    accept(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 1; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0
        || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy %b done %b stall %b result %h",
               busy, done, stall, result);
    end
    run_op("mul_3x4", 2'b00, 32'd3, 32'd4, 32'h0000000C);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_arith();
    test_start_ignored();
    test_flush_busy();
    test_flush_done();
    test_flush_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
